// File: rtl/mem_access_unit.sv
// Single-outstanding RAM command sequencer: reads take 2 cycles and writes 1 cycle, or 3 with MEM_WRITE_VERIFY_EN (read-back compare).
// Backpressure: Req_Ready is high only in IDLE, and the response holds until Resp_Ready.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 6,
    parameter int INST_WIDTH = 21
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req_Valid,
    output logic                  Req_Ready,
    input  logic [1:0]            Req_Op,
    input  logic [ADDR_WIDTH-1:0] Req_Addr,
    input  logic [DATA_WIDTH-1:0] Req_Data,
    input  logic [INST_WIDTH-1:0] Req_Inst,
    output logic                  Resp_Valid,
    input  logic                  Resp_Ready,
    output logic [DATA_WIDTH-1:0] Resp_Data,
    output logic [INST_WIDTH-1:0] Resp_Inst,
    output logic                  Resp_Err,
    output logic                  Ram_Data_Read,
    output logic                  Ram_Data_Write,
    output logic                  Ram_Inst_Read,
    output logic                  Ram_Inst_Write,
    output logic [ADDR_WIDTH-1:0] Ram_Addr,
    output logic [ADDR_WIDTH-1:0] Inst_Addr,
    output logic [DATA_WIDTH-1:0] Ram_Data_In,
    output logic [INST_WIDTH-1:0] Ram_Inst_In,
    input  logic [DATA_WIDTH-1:0] Ram_Data_Out,
    input  logic [INST_WIDTH-1:0] Ram_Inst_Out
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPT,
        RESP
`ifdef MEM_WRITE_VERIFY_EN
        ,
        VRD,
        VCAP
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;
    logic [INST_WIDTH-1:0]   inst_in_q, inst_in_d;
    logic                    rd_dat_q, rd_dat_d;
    logic                    wr_dat_q, wr_dat_d;
    logic                    rd_ins_q, rd_ins_d;
    logic                    wr_ins_q, wr_ins_d;
    logic                    req_rdy_q, req_rdy_d;
    logic                    resp_vld_q, resp_vld_d;
    logic [DATA_WIDTH-1:0]   resp_dat_q, resp_dat_d;
    logic [INST_WIDTH-1:0]   resp_ins_q, resp_ins_d;
`ifdef MEM_WRITE_VERIFY_EN
    logic                    resp_err_q, resp_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_in_d  = data_in_q;
        inst_in_d  = inst_in_q;
        rd_dat_d   = 1'b0;
        wr_dat_d   = 1'b0;
        rd_ins_d   = 1'b0;
        wr_ins_d   = 1'b0;
        req_rdy_d  = req_rdy_q;
        resp_vld_d = resp_vld_q;
        resp_dat_d = resp_dat_q;
        resp_ins_d = resp_ins_q;
`ifdef MEM_WRITE_VERIFY_EN
        resp_err_d = resp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (Req_Valid && req_rdy_q) begin
                    state_d   = ISSUE;
                    op_d      = Req_Op;
                    addr_d    = Req_Addr;
                    data_in_d = Req_Data;
                    inst_in_d = Req_Inst;
                    req_rdy_d = 1'b0;
                    // Strobes are registered, so they are raised on the accept edge to be live during ISSUE.
                    rd_dat_d  = (Req_Op == 2'b00);
                    wr_dat_d  = (Req_Op == 2'b01);
                    rd_ins_d  = (Req_Op == 2'b10);
                    wr_ins_d  = (Req_Op == 2'b11);
                end
            end
            ISSUE: begin
                if (!op_q[0]) begin
                    state_d = CAPT;
                end else begin
`ifdef MEM_WRITE_VERIFY_EN
                    state_d  = VRD;
                    rd_dat_d = !op_q[1];
                    rd_ins_d = op_q[1];
`else
                    state_d    = RESP;
                    resp_vld_d = 1'b1;
                    resp_dat_d = '0;
                    resp_ins_d = '0;
`endif
                end
            end
            CAPT: begin
                state_d    = RESP;
                resp_vld_d = 1'b1;
                resp_dat_d = op_q[1] ? '0 : Ram_Data_Out;
                resp_ins_d = op_q[1] ? Ram_Inst_Out : '0;
`ifdef MEM_WRITE_VERIFY_EN
                resp_err_d = 1'b0;
`endif
            end
`ifdef MEM_WRITE_VERIFY_EN
            VRD: begin
                state_d = VCAP;
            end
            VCAP: begin
                state_d    = RESP;
                resp_vld_d = 1'b1;
                resp_dat_d = '0;
                resp_ins_d = '0;
                resp_err_d = op_q[1] ? (Ram_Inst_Out != inst_in_q)
                                     : (Ram_Data_Out != data_in_q);
            end
`endif
            RESP: begin
                if (Resp_Ready) begin
                    state_d    = IDLE;
                    resp_vld_d = 1'b0;
                    req_rdy_d  = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                req_rdy_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            addr_q     <= '0;
            data_in_q  <= '0;
            inst_in_q  <= '0;
            rd_dat_q   <= 1'b0;
            wr_dat_q   <= 1'b0;
            rd_ins_q   <= 1'b0;
            wr_ins_q   <= 1'b0;
            req_rdy_q  <= 1'b1;
            resp_vld_q <= 1'b0;
            resp_dat_q <= '0;
            resp_ins_q <= '0;
`ifdef MEM_WRITE_VERIFY_EN
            resp_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_in_q  <= data_in_d;
            inst_in_q  <= inst_in_d;
            rd_dat_q   <= rd_dat_d;
            wr_dat_q   <= wr_dat_d;
            rd_ins_q   <= rd_ins_d;
            wr_ins_q   <= wr_ins_d;
            req_rdy_q  <= req_rdy_d;
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
            resp_ins_q <= resp_ins_d;
`ifdef MEM_WRITE_VERIFY_EN
            resp_err_q <= resp_err_d;
`endif
        end
    end

    assign Req_Ready      = req_rdy_q;
    assign Resp_Valid     = resp_vld_q;
    assign Resp_Data      = resp_dat_q;
    assign Resp_Inst      = resp_ins_q;
    assign Ram_Data_Read  = rd_dat_q;
    assign Ram_Data_Write = wr_dat_q;
    assign Ram_Inst_Read  = rd_ins_q;
    assign Ram_Inst_Write = wr_ins_q;
    assign Ram_Addr       = addr_q;
    assign Inst_Addr      = addr_q;
    assign Ram_Data_In    = data_in_q;
    assign Ram_Inst_In    = inst_in_q;
`ifdef MEM_WRITE_VERIFY_EN
    assign Resp_Err       = resp_err_q;
`else
    assign Resp_Err       = 1'b0;
`endif

endmodule
